// File: rtl/piece_drop_engine_pkg.sv
// Shared definitions for the piece drop engine and the main game FSM:
// game/engine state encodings, playfield defaults and field widths.
package piece_drop_engine_pkg;

  localparam int COLS_DEFAULT       = 10;
  localparam int ROWS_DEFAULT       = 16;
  localparam int GRAV_TICKS_DEFAULT = 8;

  localparam int COL_W = 4;
  localparam int ROW_W = 4;
  localparam int HGT_W = 5;
  localparam int LEN_W = 3;

  typedef enum logic [2:0] {
    FSM_IDLE  = 3'd0,
    FSM_SPAWN = 3'd1,
    FSM_FALL  = 3'd2,
    FSM_PLACE = 3'd3,
    FSM_OVER  = 3'd4
  } game_fsm_e;

  typedef enum logic [2:0] {
    E_IDLE  = 3'd0,
    E_SPAWN = 3'd1,
    E_FALL  = 3'd2,
    E_LOCK  = 3'd3,
    E_OVER  = 3'd4
  } engine_state_e;

  // Out-of-range lengths are pinned to the nearest legal piece size.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if (len == '0) return LEN_W'(1);
    if (len > LEN_W'(4)) return LEN_W'(4);
    return len;
  endfunction

endpackage

// File: rtl/piece_drop_engine_collision.sv
// Combinational collision logic: sideways-move legality, gravity legality,
// landing row of the current column and spawn collision.
module drop_collision_check
  import piece_drop_engine_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT
) (
  input  logic [COLS*HGT_W-1:0] heights_i,
  input  logic [COL_W-1:0]      piece_col_i,
  input  logic [ROW_W-1:0]      piece_row_i,
  input  logic [LEN_W-1:0]      spawn_len_i,
  output logic                  left_ok_o,
  output logic                  right_ok_o,
  output logic                  fall_ok_o,
  output logic                  spawn_collide_o,
  output logic [ROW_W-1:0]      land_row_o
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  localparam logic [COL_W-1:0] MID_COL  = COL_W'(COLS / 2);
  localparam logic [HGT_W-1:0] ROWS_H   = HGT_W'(ROWS);

  logic [HGT_W-1:0] col_h [COLS];
  logic [COL_W-1:0] left_idx;
  logic [COL_W-1:0] right_idx;
  logic [HGT_W-1:0] row_h;
  logic [HGT_W-1:0] cur_h;

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_unpack
      assign col_h[gi] = heights_i[gi*HGT_W +: HGT_W];
    end
  endgenerate

  always_comb begin
    // Neighbour indices are clamped so the lookup stays in range at the walls.
    left_idx        = (piece_col_i == '0) ? piece_col_i : piece_col_i - 1'b1;
    right_idx       = (piece_col_i == LAST_COL) ? piece_col_i : piece_col_i + 1'b1;
    row_h           = {1'b0, piece_row_i};
    cur_h           = col_h[piece_col_i];
    left_ok_o       = (piece_col_i != '0) && (col_h[left_idx] <= row_h);
    right_ok_o      = (piece_col_i < LAST_COL) && (col_h[right_idx] <= row_h);
    fall_ok_o       = row_h > cur_h;
    land_row_o      = cur_h[ROW_W-1:0];
    spawn_collide_o = col_h[MID_COL] > (ROWS_H - HGT_W'(spawn_len_i));
  end

endmodule

// File: rtl/piece_drop_engine.sv
// Piece drop engine: spawns a vertical piece, applies gravity and moves,
// locks it onto the per-column height map and reports placement/game over.
module piece_drop_engine
  import piece_drop_engine_pkg::*;
#(
  parameter int COLS       = COLS_DEFAULT,
  parameter int ROWS       = ROWS_DEFAULT,
  parameter int GRAV_TICKS = GRAV_TICKS_DEFAULT
) (
  input  logic       in_clka,
  input  logic       restart_n,
  input  logic [2:0] fsm_state,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       hard_drop,
  input  logic [2:0] piece_len,
  output logic [3:0] piece_row,
  output logic [3:0] piece_col,
  output logic       placed,
  output logic       game_over
);

  localparam int               CNT_W     = (GRAV_TICKS > 1) ? $clog2(GRAV_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(GRAV_TICKS - 1);
  localparam logic [COL_W-1:0] MID_COL   = COL_W'(COLS / 2);
  localparam logic [HGT_W-1:0] ROWS_H    = HGT_W'(ROWS);

  engine_state_e          state_q, state_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic [COL_W-1:0]       col_q, col_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   go_q, go_d;
  logic                   clear_heights;
  logic                   lock_we;
  logic                   grav_tick;
  logic [LEN_W-1:0]       spawn_len;
  logic [HGT_W-1:0]       lock_height;
  logic [COLS*HGT_W-1:0]  heights_flat;
  logic                   left_ok, right_ok, fall_ok, spawn_collide;
  logic [ROW_W-1:0]       land_row;

  assign spawn_len   = clamp_len(piece_len);
  assign lock_height = {1'b0, row_q} + HGT_W'(len_q);
  assign grav_tick   = (cnt_q == LAST_TICK);

  drop_collision_check #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_check (
    .heights_i       (heights_flat),
    .piece_col_i     (col_q),
    .piece_row_i     (row_q),
    .spawn_len_i     (spawn_len),
    .left_ok_o       (left_ok),
    .right_ok_o      (right_ok),
    .fall_ok_o       (fall_ok),
    .spawn_collide_o (spawn_collide),
    .land_row_o      (land_row)
  );

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    go_d          = go_q;
    clear_heights = 1'b0;
    lock_we       = 1'b0;

    case (state_q)
      E_IDLE: begin
        if (fsm_state == FSM_IDLE) begin
          clear_heights = 1'b1;
          go_d          = 1'b0;
        end else if (fsm_state == FSM_SPAWN) begin
          state_d = E_SPAWN;
        end
      end
      E_SPAWN: begin
        len_d = spawn_len;
        col_d = MID_COL;
        row_d = ROW_W'(ROWS_H - HGT_W'(spawn_len));
        cnt_d = '0;
        if (spawn_collide) begin
          state_d = E_OVER;
          go_d    = 1'b1;
        end else begin
          state_d = E_FALL;
        end
      end
      E_FALL: begin
        if (fsm_state == FSM_FALL) begin
          cnt_d = grav_tick ? '0 : cnt_q + 1'b1;
          // Gravity owns the tick cycle; moves are only honoured in between.
          if (grav_tick) begin
            if (fall_ok) row_d = row_q - 1'b1;
            else         state_d = E_LOCK;
          end else if (hard_drop) begin
            row_d   = land_row;
            state_d = E_LOCK;
          end else if (move_left && !move_right && left_ok) begin
            col_d = col_q - 1'b1;
          end else if (move_right && !move_left && right_ok) begin
            col_d = col_q + 1'b1;
          end
        end
      end
      E_LOCK: begin
        lock_we = 1'b1;
        state_d = E_IDLE;
      end
      E_OVER: begin
        go_d = 1'b1;
      end
      default: begin
        state_d = E_IDLE;
      end
    endcase

    if (fsm_state == FSM_IDLE) state_d = E_IDLE;
  end

  always_ff @(posedge in_clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q <= E_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      go_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      go_q    <= go_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < COLS; gi++) begin : g_col
      logic [HGT_W-1:0] height_q;
      always_ff @(posedge in_clka or negedge restart_n) begin
        if (!restart_n)                                  height_q <= '0;
        else if (clear_heights)                          height_q <= '0;
        else if (lock_we && (col_q == COL_W'(gi)))       height_q <= lock_height;
      end
      assign heights_flat[gi*HGT_W +: HGT_W] = height_q;
    end
  endgenerate

  assign piece_row = row_q;
  assign piece_col = col_q;
  assign placed    = (state_q == E_LOCK);
  assign game_over = go_q;

endmodule
